// File: rtl/hook_sprite_renderer.sv
// hook_sprite_renderer: overlays the 16x16 hook sprite ROM onto the VGA pixel stream.
// Anchor updates use a valid/ready handshake and are applied only at frame_start.
// Optional build macro: HOOK_SCALE2X_EN doubles the sprite to 2x2 pixels per texel.
module hook_sprite_renderer #(
  parameter int unsigned SPRITE_W  = 16,
  parameter int unsigned SPRITE_H  = 16,
  parameter logic [11:0] KEY_COLOR = 12'h0F0,
  parameter logic [9:0]  HOME_X    = 10'd312,
  parameter logic [9:0]  HOME_Y    = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  input  logic [11:0] bg_rgb,
  output logic [3:0]  rom_row,
  output logic [3:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb_out,
  output logic        hook_on
);

`ifdef HOOK_SCALE2X_EN
  localparam int unsigned BOX_W    = 2 * SPRITE_W;
  localparam int unsigned BOX_H    = 2 * SPRITE_H;
  localparam int unsigned TEX_SH   = 1;
`else
  localparam int unsigned BOX_W    = SPRITE_W;
  localparam int unsigned BOX_H    = SPRITE_H;
  localparam int unsigned TEX_SH   = 0;
`endif
  localparam int unsigned CW       = 11;

  logic [9:0]    act_x, act_y;
  logic [9:0]    pend_x, pend_y;
  logic          pending_full;
  logic          pending_full_nxt;
  logic          xfer;

  logic [CW-1:0] dx, dy;
  logic [CW-1:0] x_end, y_end;
  logic          in_box;

  logic          in_box_d;
  logic          video_d;
  logic [11:0]   bg_d;

  // Next occupancy of the pending slot; a transfer can only happen when the slot is empty
  always_comb begin
    xfer             = pos_valid && pos_ready;
    pending_full_nxt = pending_full;
    if (xfer) begin
      pending_full_nxt = 1'b1;
    end else if (frame_start) begin
      pending_full_nxt = 1'b0;
    end
  end

  // Pending slot and active anchor; the anchor only moves at frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_x       <= '0;
      pend_y       <= '0;
      pending_full <= 1'b0;
      pos_ready    <= 1'b1;
      act_x        <= HOME_X;
      act_y        <= HOME_Y;
    end else begin
      if (xfer) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_start && pending_full) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
      pending_full <= pending_full_nxt;
      pos_ready    <= !pending_full_nxt;
    end
  end

  // Stage 0: screen to sprite mapping, 11-bit arithmetic so the box never wraps
  always_comb begin
    dx     = {1'b0, pix_x} - {1'b0, act_x};
    dy     = {1'b0, pix_y} - {1'b0, act_y};
    x_end  = {1'b0, act_x} + CW'(BOX_W);
    y_end  = {1'b0, act_y} + CW'(BOX_H);
    in_box = video_on
          && (pix_x >= act_x) && ({1'b0, pix_x} < x_end)
          && (pix_y >= act_y) && ({1'b0, pix_y} < y_end);
    rom_row = '0;
    rom_col = '0;
    if (in_box) begin
      rom_row = 4'(dy >> TEX_SH);
      rom_col = 4'(dx >> TEX_SH);
    end
  end

  // Stage 1: delay pixel attributes to line up with the ROM read
  always_ff @(posedge clk) begin
    if (reset) begin
      in_box_d <= 1'b0;
      video_d  <= 1'b0;
      bg_d     <= '0;
    end else begin
      in_box_d <= in_box;
      video_d  <= video_on;
      bg_d     <= bg_rgb;
    end
  end

  // Stage 2: blank, opaque texel, or background
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out <= '0;
      hook_on <= 1'b0;
    end else if (!video_d) begin
      rgb_out <= '0;
      hook_on <= 1'b0;
    end else if (in_box_d && (rom_data != KEY_COLOR)) begin
      rgb_out <= rom_data;
      hook_on <= 1'b1;
    end else begin
      rgb_out <= bg_d;
      hook_on <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hook_sprite_renderer.sv
// Directed bench for hook_sprite_renderer; expectations follow HOOK_SCALE2X_EN if defined.
module tb_hook_sprite_renderer;

`ifdef HOOK_SCALE2X_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [9:0]  pos_x, pos_y;
  logic        pos_valid;
  logic        pos_ready;
  logic [9:0]  pix_x, pix_y;
  logic        video_on;
  logic [11:0] bg_rgb;
  logic [3:0]  rom_row, rom_col;
  logic [11:0] rom_data;
  logic [11:0] rgb_out;
  logic        hook_on;

  int n_checks = 0;
  int n_fail   = 0;

  hook_sprite_renderer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on), .bg_rgb(bg_rgb),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .rgb_out(rgb_out), .hook_on(hook_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel, check the ROM address, return rom at N+1, check the output at N+2
  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic v, input logic [11:0] bg, input logic [11:0] rom,
                       input logic [3:0] er, input logic [3:0] ec,
                       input logic [11:0] ergb, input logic eh);
    pix_x = x; pix_y = y; video_on = v; bg_rgb = bg;
    #1;
    check({tag, ".row"}, 32'(rom_row), 32'(er));
    check({tag, ".col"}, 32'(rom_col), 32'(ec));
    step();
    rom_data = rom;
    step();
    check({tag, ".rgb"}, 32'(rgb_out), 32'(ergb));
    check({tag, ".hook"}, 32'(hook_on), 32'(eh));
  endtask

  task automatic set_anchor(input logic [9:0] x, input logic [9:0] y);
    pos_x = x; pos_y = y; pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    check("anchor.ready_low", 32'(pos_ready), 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("anchor.ready_high", 32'(pos_ready), 32'd1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; pos_x = '0; pos_y = '0; pos_valid = 1'b0;
    pix_x = '0; pix_y = '0; video_on = 1'b0; bg_rgb = '0; rom_data = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst.rgb", 32'(rgb_out), 32'd0);
    check("rst.hook", 32'(hook_on), 32'd0);
    check("rst.ready", 32'(pos_ready), 32'd1);

    // Home anchor (312,0)
    pixel("home0", 10'd312, 10'd0, 1'b1, 12'h111, 12'h0F0, 4'd0, 4'd0, 12'h111, 1'b0);
    pixel("home2", 10'd314, 10'd2, 1'b1, 12'h111, 12'hABC,
          SC ? 4'd1 : 4'd2, SC ? 4'd1 : 4'd2, 12'hABC, 1'b1);

    set_anchor(10'd100, 10'd50);
    pixel("opaque", 10'd105, 10'd52, 1'b1, 12'h456, 12'hFFF,
          SC ? 4'd1 : 4'd2, SC ? 4'd2 : 4'd5, 12'hFFF, 1'b1);
    pixel("key", 10'd100, 10'd50, 1'b1, 12'h123, 12'h0F0, 4'd0, 4'd0, 12'h123, 1'b0);
    pixel("right_edge", 10'd116, 10'd50, 1'b1, 12'h321, 12'hABC,
          4'd0, SC ? 4'd8 : 4'd0, SC ? 12'hABC : 12'h321, SC);
    pixel("corner", 10'd115, 10'd65, 1'b1, 12'h321, 12'h777,
          SC ? 4'd7 : 4'd15, SC ? 4'd7 : 4'd15, 12'h777, 1'b1);
    pixel("left_out", 10'd99, 10'd50, 1'b1, 12'h222, 12'h777, 4'd0, 4'd0, 12'h222, 1'b0);
    if (SC) begin
      pixel("x2_a", 10'd111, 10'd55, 1'b1, 12'h222, 12'h777, 4'd2, 4'd5, 12'h777, 1'b1);
      pixel("x2_b", 10'd131, 10'd50, 1'b1, 12'h222, 12'h777, 4'd0, 4'd15, 12'h777, 1'b1);
    end

    // Request mid-frame: held pending until frame_start; second request refused
    pos_x = 10'd200; pos_y = 10'd200; pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    check("mid.ready_low", 32'(pos_ready), 32'd0);
    pixel("mid.before", 10'd205, 10'd205, 1'b1, 12'h0AA, 12'h555, 4'd0, 4'd0, 12'h0AA, 1'b0);
    pos_x = 10'd300; pos_y = 10'd300; pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    check("mid.ready_still_low", 32'(pos_ready), 32'd0);
    pulse_frame();
    check("mid.ready_back", 32'(pos_ready), 32'd1);
    pixel("mid.after", 10'd205, 10'd205, 1'b1, 12'h0AA, 12'h555,
          SC ? 4'd2 : 4'd5, SC ? 4'd2 : 4'd5, 12'h555, 1'b1);
    pixel("second_lost", 10'd305, 10'd305, 1'b1, 12'h0BB, 12'h555, 4'd0, 4'd0, 12'h0BB, 1'b0);
    pixel("blank", 10'd205, 10'd205, 1'b0, 12'h0AA, 12'h555, 4'd0, 4'd0, 12'h000, 1'b0);

    // frame_start with empty slot keeps the anchor
    pulse_frame();
    pixel("empty_fs", 10'd205, 10'd205, 1'b1, 12'h0AA, 12'h555,
          SC ? 4'd2 : 4'd5, SC ? 4'd2 : 4'd5, 12'h555, 1'b1);

    // Transfer coinciding with frame_start waits for the next frame_start
    pos_x = 10'd400; pos_y = 10'd100; pos_valid = 1'b1; frame_start = 1'b1;
    step();
    pos_valid = 1'b0; frame_start = 1'b0;
    check("same.ready_low", 32'(pos_ready), 32'd0);
    pixel("same.old", 10'd205, 10'd205, 1'b1, 12'h0AA, 12'h555,
          SC ? 4'd2 : 4'd5, SC ? 4'd2 : 4'd5, 12'h555, 1'b1);
    pulse_frame();
    pixel("same.new", 10'd405, 10'd105, 1'b1, 12'h0AA, 12'h666,
          SC ? 4'd2 : 4'd5, SC ? 4'd2 : 4'd5, 12'h666, 1'b1);

    // Edge anchors: clipping and no wrap near 1023
    set_anchor(10'd630, 10'd0);
    pixel("edge630", 10'd639, 10'd0, 1'b1, 12'h0CC, 12'h888,
          4'd0, SC ? 4'd4 : 4'd9, 12'h888, 1'b1);
    set_anchor(10'd1020, 10'd0);
    pixel("edge1020", 10'd1023, 10'd0, 1'b1, 12'h0CC, 12'h999,
          4'd0, SC ? 4'd1 : 4'd3, 12'h999, 1'b1);
    pixel("wrap_low", 10'd2, 10'd0, 1'b1, 12'h0CC, 12'h999, 4'd0, 4'd0, 12'h0CC, 1'b0);

    // Reset mid-frame: flush pipeline, drop pending, return home
    pix_x = 10'd1023; pix_y = 10'd0; video_on = 1'b1; bg_rgb = 12'h0CC; rom_data = 12'hFFF;
    step(); step();
    check("pre_rst.rgb", 32'(rgb_out), 32'hFFF);
    pos_x = 10'd10; pos_y = 10'd10; pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst.rgb0", 32'(rgb_out), 32'd0);
    check("mid_rst.hook0", 32'(hook_on), 32'd0);
    check("mid_rst.ready", 32'(pos_ready), 32'd1);
    step();
    check("mid_rst.rgb1", 32'(rgb_out), 32'd0);
    pulse_frame();
    pixel("rst.home", 10'd313, 10'd1, 1'b1, 12'h0DD, 12'hE00,
          SC ? 4'd0 : 4'd1, SC ? 4'd0 : 4'd1, 12'hE00, 1'b1);
    pixel("rst.dropped", 10'd15, 10'd15, 1'b1, 12'h0DD, 12'hE00, 4'd0, 4'd0, 12'h0DD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
